pkt_read_free_ctrl: RTL and testbench

Parametrised packet read/free controller for the control output path. Accepts packet descriptors from the output scheduler, reads the packet line by line from the packet-centralized buffer (PCB), and returns buffer IDs to the PCB free list. Generalises bufid, inport and lines-per-buffer widths and the first-line gap. Adds three things: a free-request FIFO so back-to-back frees are never lost, an oversize-packet abort, and a level-based descriptor handshake.

---
 rtl/pkt_read_free_ctrl_if.sv | 46 ++++
 rtl/pkt_read_free_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pkt_read_free_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pkt_read_free_ctrl_if.sv
// rtl/pkt_read_free_ctrl_if.sv - descriptor, free-list and PCB read handshake bundle
//
// Ports (signals):
//   iv_pkt_descriptor / i_pkt_descriptor_wr / o_pkt_descriptor_ready : {inport, bufid} descriptor in
//   ov_pkt_bufid / o_pkt_bufid_wr / i_pkt_bufid_ack                  : bufid free request out
//   ov_pkt_raddr / o_pkt_rd / i_pkt_raddr_ack                        : PCB line read request out
//   i_pkt_rd_req / i_pkt_rx_valid / i_pkt_last_cycle_rx              : downstream flow and line return
// Modports: master = controller side, slave = scheduler/PCB side.
interface pkt_read_free_ctrl_if #(
  parameter int BUFID_W    = 9,
  parameter int INPORT_W   = 4,
  parameter int LINE_SHIFT = 7
);
  localparam int ADDR_W = BUFID_W + LINE_SHIFT;

  logic [INPORT_W+BUFID_W-1:0] iv_pkt_descriptor;
  logic                        i_pkt_descriptor_wr;
  logic                        o_pkt_descriptor_ready;
  logic [BUFID_W-1:0]          ov_pkt_bufid;
  logic                        o_pkt_bufid_wr;
  logic                        i_pkt_bufid_ack;
  logic [ADDR_W-1:0]           ov_pkt_raddr;
  logic                        o_pkt_rd;
  logic                        i_pkt_raddr_ack;
  logic                        i_pkt_rd_req;
  logic                        i_pkt_rx_valid;
  logic                        i_pkt_last_cycle_rx;

  modport master (
    input  iv_pkt_descriptor, i_pkt_descriptor_wr,
    output o_pkt_descriptor_ready,
    output ov_pkt_bufid, o_pkt_bufid_wr,
    input  i_pkt_bufid_ack,
    output ov_pkt_raddr, o_pkt_rd,
    input  i_pkt_raddr_ack, i_pkt_rd_req, i_pkt_rx_valid, i_pkt_last_cycle_rx
  );

  modport slave (
    output iv_pkt_descriptor, i_pkt_descriptor_wr,
    input  o_pkt_descriptor_ready,
    input  ov_pkt_bufid, o_pkt_bufid_wr,
    output i_pkt_bufid_ack,
    input  ov_pkt_raddr, o_pkt_rd,
    output i_pkt_raddr_ack, i_pkt_rd_req, i_pkt_rx_valid, i_pkt_last_cycle_rx
  );
endinterface

// File: rtl/pkt_read_free_ctrl.sv
// rtl/pkt_read_free_ctrl.sv - packet read/free controller for the control output path
//
// Reads each described packet line by line from the PCB and returns its bufid to
// the PCB free list through a small free FIFO; free-only descriptors skip the read.
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   bus (master)         : descriptor in, bufid free out, PCB line read out
//   ov_pkt_inport        : inport of the packet being read
//   o_overrun            : one-cycle pulse when a packet exceeds one buffer
//   ov_read_state        : read FSM state (debug)
//   ov_desc_cnt          : accepted descriptors, wrapping
//   ov_free_cnt          : acknowledged frees, wrapping
module pkt_read_free_ctrl #(
  parameter int BUFID_W    = 9,
  parameter int INPORT_W   = 4,
  parameter int LINE_SHIFT = 7,
  parameter int FIRST_GAP  = 9,
  parameter int FREE_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pkt_read_free_ctrl_if.master bus,
  output logic [INPORT_W-1:0] ov_pkt_inport,
  output logic                o_overrun,
  output logic [2:0]          ov_read_state,
  output logic [15:0]         ov_desc_cnt,
  output logic [15:0]         ov_free_cnt
);
  localparam int ADDR_W = BUFID_W + LINE_SHIFT;
  localparam int PTR_W  = $clog2(FREE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    RD_IDLE     = 3'd0,
    RD_FIRST    = 3'd1,
    RD_WAIT_ACK = 3'd2,
    RD_WAIT_RX  = 3'd3,
    RD_WAIT_CYC = 3'd4,
    RD_GAP      = 3'd5,
    RD_NEXT     = 3'd6
  } rd_state_t;

  typedef enum logic {
    FR_IDLE = 1'b0,
    FR_WAIT = 1'b1
  } fr_state_t;

  rd_state_t             rd_state;
  fr_state_t             fr_state;
  logic [BUFID_W-1:0]    bufid_q;
  logic [LINE_SHIFT-1:0] line_idx;
  logic [3:0]            gap_cnt;
  logic [ADDR_W-1:0]     raddr_q;
  logic                  rd_q;
  logic [BUFID_W-1:0]    free_bufid_q;
  logic                  free_wr_q;

  logic [BUFID_W-1:0]    fifo_mem [FREE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  logic [BUFID_W-1:0]    desc_bufid;
  logic [INPORT_W-1:0]   desc_inport;
  logic                  desc_ready;
  logic                  accept;
  logic                  free_only;
  logic                  pkt_end;
  logic                  pkt_abort;
  logic                  push;
  logic [BUFID_W-1:0]    push_data;
  logic                  pop;

  assign desc_bufid  = bus.iv_pkt_descriptor[BUFID_W-1:0];
  assign desc_inport = bus.iv_pkt_descriptor[BUFID_W +: INPORT_W];
  assign free_only   = &desc_inport;

  // Only IDLE accepts, and a full FIFO blocks acceptance; a read packet
  // therefore owns a free slot from acceptance until its own end-of-packet push.
  assign desc_ready = (rd_state == RD_IDLE) && (fifo_cnt != CNT_W'(FREE_DEPTH));
  assign accept     = bus.i_pkt_descriptor_wr && desc_ready;

  assign pkt_end   = ((rd_state == RD_WAIT_CYC) || (rd_state == RD_NEXT)) && bus.i_pkt_last_cycle_rx;
  assign pkt_abort = (rd_state == RD_NEXT) && !bus.i_pkt_last_cycle_rx && bus.i_pkt_rd_req && (&line_idx);

  assign push      = (accept && free_only) || pkt_end || pkt_abort;
  assign push_data = (rd_state == RD_IDLE) ? desc_bufid : bufid_q;
  assign pop       = (fr_state == FR_WAIT) && bus.i_pkt_bufid_ack;

  assign bus.o_pkt_descriptor_ready = desc_ready;
  assign bus.ov_pkt_raddr           = raddr_q;
  assign bus.o_pkt_rd               = rd_q;
  assign bus.ov_pkt_bufid           = free_bufid_q;
  assign bus.o_pkt_bufid_wr         = free_wr_q;
  assign ov_read_state              = rd_state;

  // Read FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state      <= RD_IDLE;
      bufid_q       <= '0;
      line_idx      <= '0;
      gap_cnt       <= '0;
      raddr_q       <= '0;
      rd_q          <= 1'b0;
      ov_pkt_inport <= '0;
      o_overrun     <= 1'b0;
      ov_desc_cnt   <= '0;
    end else begin
      o_overrun <= 1'b0;
      if (accept) ov_desc_cnt <= ov_desc_cnt + 16'd1;
      case (rd_state)
        RD_IDLE: begin
          if (accept && !free_only) begin
            bufid_q       <= desc_bufid;
            ov_pkt_inport <= desc_inport;
            line_idx      <= '0;
            rd_state      <= RD_FIRST;
          end
        end
        RD_FIRST: begin
          if (bus.i_pkt_rd_req) begin
            raddr_q  <= {bufid_q, {LINE_SHIFT{1'b0}}};
            rd_q     <= 1'b1;
            rd_state <= RD_WAIT_ACK;
          end
        end
        RD_WAIT_ACK: begin
          if (bus.i_pkt_raddr_ack) begin
            rd_q     <= 1'b0;
            rd_state <= RD_WAIT_RX;
          end
        end
        RD_WAIT_RX: begin
          if (bus.i_pkt_rx_valid) rd_state <= RD_WAIT_CYC;
        end
        RD_WAIT_CYC: begin
          if (bus.i_pkt_last_cycle_rx) begin
            rd_state <= RD_IDLE;
          end else if (line_idx == '0) begin
            gap_cnt  <= '0;
            rd_state <= RD_GAP;
          end else begin
            rd_state <= RD_NEXT;
          end
        end
        RD_GAP: begin
          // Fixed wait after the first line; downstream readiness is not consulted.
          if (gap_cnt == 4'(FIRST_GAP - 1)) begin
            raddr_q  <= {bufid_q, line_idx + 1'b1};
            line_idx <= line_idx + 1'b1;
            rd_q     <= 1'b1;
            rd_state <= RD_WAIT_ACK;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        RD_NEXT: begin
          if (bus.i_pkt_last_cycle_rx) begin
            rd_state <= RD_IDLE;
          end else if (bus.i_pkt_rd_req) begin
            if (&line_idx) begin
              // Buffer exhausted without a last line: drop the packet, free its buffer.
              o_overrun <= 1'b1;
              rd_state  <= RD_IDLE;
            end else begin
              // Only the line field advances, so the address never leaves the buffer.
              raddr_q  <= {bufid_q, line_idx + 1'b1};
              line_idx <= line_idx + 1'b1;
              rd_q     <= 1'b1;
              rd_state <= RD_WAIT_ACK;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Free FIFO storage; occupancy is tracked by fifo_cnt, so contents need no reset.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  // Free FIFO pointers and free FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      fr_state     <= FR_IDLE;
      free_bufid_q <= '0;
      free_wr_q    <= 1'b0;
      ov_free_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      case (fr_state)
        FR_IDLE: begin
          if (fifo_cnt != '0) begin
            free_bufid_q <= fifo_mem[rd_ptr];
            free_wr_q    <= 1'b1;
            fr_state     <= FR_WAIT;
          end
        end
        FR_WAIT: begin
          if (bus.i_pkt_bufid_ack) begin
            free_wr_q   <= 1'b0;
            ov_free_cnt <= ov_free_cnt + 16'd1;
            fr_state    <= FR_IDLE;
          end
        end
        default: fr_state <= FR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_read_free_ctrl.sv
// tb/tb_pkt_read_free_ctrl.sv - directed bench for pkt_read_free_ctrl (wide and LINE_SHIFT=2 instances)
//
// Both instances see identical stimulus; the LINE_SHIFT=2 instance covers the oversize abort.
module tb_pkt_read_free_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [12:0] desc      = '0;
  logic        desc_wr   = 1'b0;
  logic        bufid_ack = 1'b0;
  logic        raddr_ack = 1'b0;
  logic        rd_req    = 1'b0;
  logic        rx_valid  = 1'b0;
  logic        last_rx   = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pkt_read_free_ctrl_if #(.BUFID_W(9), .INPORT_W(4), .LINE_SHIFT(7)) a_if ();
  pkt_read_free_ctrl_if #(.BUFID_W(9), .INPORT_W(4), .LINE_SHIFT(2)) b_if ();

  assign a_if.iv_pkt_descriptor   = desc;
  assign a_if.i_pkt_descriptor_wr = desc_wr;
  assign a_if.i_pkt_bufid_ack     = bufid_ack;
  assign a_if.i_pkt_raddr_ack     = raddr_ack;
  assign a_if.i_pkt_rd_req        = rd_req;
  assign a_if.i_pkt_rx_valid      = rx_valid;
  assign a_if.i_pkt_last_cycle_rx = last_rx;
  assign b_if.iv_pkt_descriptor   = desc;
  assign b_if.i_pkt_descriptor_wr = desc_wr;
  assign b_if.i_pkt_bufid_ack     = bufid_ack;
  assign b_if.i_pkt_raddr_ack     = raddr_ack;
  assign b_if.i_pkt_rd_req        = rd_req;
  assign b_if.i_pkt_rx_valid      = rx_valid;
  assign b_if.i_pkt_last_cycle_rx = last_rx;

  logic [3:0]  a_inport, b_inport;
  logic        a_ovr, b_ovr;
  logic [2:0]  a_st, b_st;
  logic [15:0] a_dcnt, b_dcnt, a_fcnt, b_fcnt;

  pkt_read_free_ctrl #(.BUFID_W(9), .INPORT_W(4), .LINE_SHIFT(7), .FIRST_GAP(9), .FREE_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .bus(a_if.master),
    .ov_pkt_inport(a_inport), .o_overrun(a_ovr), .ov_read_state(a_st),
    .ov_desc_cnt(a_dcnt), .ov_free_cnt(a_fcnt)
  );

  pkt_read_free_ctrl #(.BUFID_W(9), .INPORT_W(4), .LINE_SHIFT(2), .FIRST_GAP(9), .FREE_DEPTH(4)) dut_s (
    .i_clk(clk), .i_rst(rst), .bus(b_if.master),
    .ov_pkt_inport(b_inport), .o_overrun(b_ovr), .ov_read_state(b_st),
    .ov_desc_cnt(b_dcnt), .ov_free_cnt(b_fcnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int nfree;
    int rd_seen;
    logic [8:0] got_free [4];

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_rd", a_if.o_pkt_rd, 0);
    check_eq("rst_raddr", a_if.ov_pkt_raddr, 0);
    check_eq("rst_bufid_wr", a_if.o_pkt_bufid_wr, 0);
    check_eq("rst_state", a_st, 0);
    check_eq("rst_ready", a_if.o_pkt_descriptor_ready, 1);
    check_eq("rst_cnts", {a_dcnt, a_fcnt}, 0);
    check_eq("rst_ovr", a_ovr, 0);

    // Three-line packet {2, 5}
    rd_req = 1'b1;
    desc = {4'h2, 9'd5}; desc_wr = 1'b1;
    tick(); desc_wr = 1'b0;
    check_eq("p1_state_first", a_st, 1);
    check_eq("p1_ready_low", a_if.o_pkt_descriptor_ready, 0);
    tick();
    check_eq("p1_rd0", a_if.o_pkt_rd, 1);
    check_eq("p1_raddr0", a_if.ov_pkt_raddr, 32'h280);
    check_eq("p1_inport", a_inport, 2);
    raddr_ack = 1'b1; tick(); raddr_ack = 1'b0;
    check_eq("p1_rd_drop", a_if.o_pkt_rd, 0);
    check_eq("p1_state_rx", a_st, 3);
    rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    check_eq("p1_state_cyc", a_st, 4);
    // Gap must not depend on rd_req
    rd_req = 1'b0;
    cnt = 0;
    do begin tick(); cnt++; end while (!a_if.o_pkt_rd && cnt < 30);
    check_eq("p1_gap_cycles", cnt, 10);
    check_eq("p1_raddr1", a_if.ov_pkt_raddr, 32'h281);
    raddr_ack = 1'b1; tick(); raddr_ack = 1'b0;
    rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    tick();
    check_eq("p1_state_next", a_st, 6);
    rd_seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (a_if.o_pkt_rd) rd_seen++; end
    check_eq("p1_no_rd_stalled", rd_seen, 0);
    check_eq("p1_still_next", a_st, 6);
    rd_req = 1'b1; tick();
    check_eq("p1_rd2", a_if.o_pkt_rd, 1);
    check_eq("p1_raddr2", a_if.ov_pkt_raddr, 32'h282);
    raddr_ack = 1'b1; tick(); raddr_ack = 1'b0;
    rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    last_rx = 1'b1; tick(); last_rx = 1'b0;
    check_eq("p1_state_idle", a_st, 0);
    check_eq("p1_ready_back", a_if.o_pkt_descriptor_ready, 1);
    check_eq("p1_wr_not_yet", a_if.o_pkt_bufid_wr, 0);
    check_eq("p1_desc_cnt", a_dcnt, 1);
    tick();
    check_eq("p1_free_wr", a_if.o_pkt_bufid_wr, 1);
    check_eq("p1_free_bufid", a_if.ov_pkt_bufid, 5);
    bufid_ack = 1'b1; tick(); bufid_ack = 1'b0;
    check_eq("p1_free_wr_drop", a_if.o_pkt_bufid_wr, 0);
    check_eq("p1_free_cnt", a_fcnt, 1);

    // Four free-only descriptors with ack withheld
    for (int i = 1; i <= 4; i++) begin
      check_eq("fo_ready", a_if.o_pkt_descriptor_ready, 1);
      desc = {4'hf, 9'(i)}; desc_wr = 1'b1;
      tick();
    end
    desc_wr = 1'b0;
    check_eq("fo_ready_full", a_if.o_pkt_descriptor_ready, 0);
    check_eq("fo_state_idle", a_st, 0);
    check_eq("fo_desc_cnt", a_dcnt, 5);
    bufid_ack = 1'b1;
    nfree = 0;
    for (int k = 0; k < 30 && nfree < 4; k++) begin
      if (a_if.o_pkt_bufid_wr) begin got_free[nfree] = a_if.ov_pkt_bufid; nfree++; end
      tick();
    end
    bufid_ack = 1'b0;
    check_eq("fo_nfree", nfree, 4);
    for (int i = 0; i < 4; i++) check_eq("fo_order", got_free[i], i + 1);
    check_eq("fo_free_cnt", a_fcnt, 5);
    check_eq("fo_ready_back", a_if.o_pkt_descriptor_ready, 1);

    // Reset mid-WAIT_RX with a pending free
    desc = {4'hf, 9'd7}; desc_wr = 1'b1; tick();
    desc = {4'h3, 9'd9}; tick(); desc_wr = 1'b0;
    tick();
    raddr_ack = 1'b1; tick(); raddr_ack = 1'b0;
    check_eq("mr_state_rx", a_st, 3);
    check_eq("mr_free_pending", a_if.o_pkt_bufid_wr, 1);
    rst = 1'b1; tick();
    check_eq("mr_rd", a_if.o_pkt_rd, 0);
    check_eq("mr_raddr", a_if.ov_pkt_raddr, 0);
    check_eq("mr_free", {a_if.o_pkt_bufid_wr, a_if.ov_pkt_bufid}, 0);
    check_eq("mr_state", a_st, 0);
    check_eq("mr_inport", a_inport, 0);
    check_eq("mr_cnts", {a_dcnt, a_fcnt}, 0);
    rst = 1'b0; tick();
    check_eq("mr_ready", a_if.o_pkt_descriptor_ready, 1);
    rd_seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (a_if.o_pkt_bufid_wr) rd_seen++; end
    check_eq("mr_no_free", rd_seen, 0);

    // Oversize packet: LINE_SHIFT=2 instance aborts after line 3, wide one continues
    rd_req = 1'b1;
    desc = {4'h1, 9'd5}; desc_wr = 1'b1; tick(); desc_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      while (!b_if.o_pkt_rd && cnt < 40) begin tick(); cnt++; end
      check_eq("ov_rd_seen", b_if.o_pkt_rd, 1);
      check_eq("ov_raddr", b_if.ov_pkt_raddr, 32'h14 + i);
      raddr_ack = 1'b1; tick(); raddr_ack = 1'b0;
      rx_valid = 1'b1; tick(); rx_valid = 1'b0;
      tick();
    end
    check_eq("ov_state_next", b_st, 6);
    tick();
    check_eq("ov_pulse", b_ovr, 1);
    check_eq("ov_no_rd", b_if.o_pkt_rd, 0);
    check_eq("ov_state_idle", b_st, 0);
    check_eq("ov_wide_rd", {a_ovr, a_if.o_pkt_rd}, 1);
    check_eq("ov_wide_raddr", a_if.ov_pkt_raddr, 32'h284);
    tick();
    check_eq("ov_pulse_end", b_ovr, 0);
    check_eq("ov_free_wr", b_if.o_pkt_bufid_wr, 1);
    check_eq("ov_free_bufid", b_if.ov_pkt_bufid, 5);
    check_eq("ov_ready", b_if.o_pkt_descriptor_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
